// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter: FSM state encoding.
package mux_sel_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_sel_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or cyclically above ptr.
module rr_priority_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  localparam logic [SEL_W:0] NV = N[SEL_W:0];

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SEL_W:0] off;
  logic [SEL_W:0] sum;
  logic           found;

  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    any    = |req;
    off    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = i[SEL_W:0];
        found = 1'b1;
      end
    end
    // Rotated offset back to an absolute index, modulo N.
    sum = {1'b0, ptr} + off;
    if (sum >= NV) begin
      sum = sum - NV;
    end
    idx    = sum[SEL_W-1:0];
    onehot = '0;
    if (any) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving an N:1 mux select with a valid/ready handshake.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [N-1:0]     ack
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [SEL_W-1:0] ptr_nxt;
  logic [N-1:0]     pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic [N-1:0]     pick_onehot;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  // While granting, the picker looks ahead past the current holder so a
  // transfer can hand over to the next winner without an idle cycle.
  assign ptr_nxt  = (sel_q == LAST) ? '0 : sel_q + SEL_W'(1);
  assign pick_req = (state_q == GRANT) ? (req & ~grant_q) : req;
  assign pick_ptr = (state_q == GRANT) ? ptr_nxt : ptr_q;

  rr_priority_pick #(.N(N)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          sel_d   = pick_idx;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (out_ready) begin
          ptr_d = ptr_nxt;
          if (pick_any) begin
            grant_d = pick_onehot;
            sel_d   = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == GRANT);
  assign ack       = grant_q & req & {N{out_ready}};

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (N=4) with a cycle-level reference model.
module tb_mux_sel_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   sel;
  logic         out_valid;
  logic [N-1:0] ack;

  int vectors = 0;
  int miscompares = 0;

  mux_sel_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the grant, and where the search starts next.
  bit m_act = 0;
  int m_sel = 0;
  int m_ptr = 0;

  function automatic int search(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_act = 0; m_sel = 0; m_ptr = 0;
    end else if (!m_act) begin
      w = search(req, m_ptr);
      if (w >= 0) begin m_act = 1; m_sel = w; end
    end else if (!req[m_sel]) begin
      m_act = 0;
    end else if (out_ready) begin
      m_ptr = (m_sel + 1) % N;
      w = search(req & ~(4'b0001 << m_sel), m_ptr);
      if (w >= 0) m_sel = w;
      else m_act = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg, ea;
    eg = m_act ? (4'b0001 << m_sel) : 4'b0000;
    ea = (m_act && req[m_sel] && out_ready) ? eg : 4'b0000;
    check("model_grant", int'(grant), int'(eg));
    check("model_sel", int'(sel), m_sel);
    check("model_valid", int'(out_valid), int'(m_act));
    check("model_ack", int'(ack), int'(ea));
  end

  // Drive inputs just after an edge, return at the following falling edge.
  task automatic drive(input logic [N-1:0] r, input logic rdy);
    @(posedge clk); #1;
    req = r; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    do_reset();
    check("reset_grant", int'(grant), 0);
    check("reset_sel", int'(sel), 0);
    check("reset_valid", int'(out_valid), 0);

    // Single requester under backpressure, then released.
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    check("single_grant", int'(grant), 4'b0100);
    check("single_sel", int'(sel), 2);
    check("single_valid", int'(out_valid), 1);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    check("single_hold_ack", int'(ack), 0);
    drive(4'b0100, 1'b1);
    check("single_ack", int'(ack), 4'b0100);
    drive(4'b0000, 1'b0);
    check("single_idle_grant", int'(grant), 0);
    check("single_idle_valid", int'(out_valid), 0);

    // Full load from reset: round-robin with no bubbles.
    do_reset();
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b1);
      check("full_grant", int'(grant), int'(seq[i]));
      check("full_sel", int'(sel), i % N);
      check("full_ack", int'(ack), int'(seq[i]));
    end

    // Backpressure holds grant.
    do_reset();
    drive(4'b0011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0011, 1'b0);
      check("bp_grant", int'(grant), 4'b0001);
      check("bp_ack", int'(ack), 0);
    end
    drive(4'b0011, 1'b1);
    check("bp_release_ack", int'(ack), 4'b0001);
    drive(4'b0011, 1'b0);
    check("bp_next_grant", int'(grant), 4'b0010);
    check("bp_next_sel", int'(sel), 1);

    // Withdraw leaves ptr unchanged.
    do_reset();
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b1);
    check("wd_grant", int'(grant), 4'b0010);
    check("wd_ack", int'(ack), 0);
    drive(4'b0011, 1'b0);
    check("wd_valid", int'(out_valid), 0);
    drive(4'b0011, 1'b0);
    check("wd_regrant", int'(grant), 4'b0001);

    // Wrap from 3 to 0, then mask the just-served requester.
    do_reset();
    drive(4'b1000, 1'b0);
    drive(4'b1001, 1'b1);
    check("wrap_grant", int'(grant), 4'b1000);
    check("wrap_ack", int'(ack), 4'b1000);
    drive(4'b0001, 1'b1);
    check("wrap_next", int'(grant), 4'b0001);
    check("wrap_sel", int'(sel), 0);
    check("mask_ack", int'(ack), 4'b0001);
    drive(4'b0001, 1'b0);
    check("mask_idle", int'(grant), 0);
    drive(4'b0001, 1'b0);
    check("mask_regrant", int'(grant), 4'b0001);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    check("pre_rst_grant", int'(grant), 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_sel", int'(sel), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b1000; out_ready = 1'b0;
    drive(4'b1000, 1'b0);
    check("post_rst_grant", int'(grant), 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the N:1 mux and drives its select input.
- Accepts up to N requesters and grants exactly one at a time.
- Presents the winner's index on sel with a valid/ready handshake toward the consumer of the mux output.
- Holds the grant stable under backpressure, so the mux output cannot change mid-transfer.

Parameters:
- N, 4, number of requesters / mux inputs; legal range N >= 2.
- SEL_W, $clog2(N), width of sel; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester request; held high until acked or withdrawn
- out_ready  input  1  downstream accepts the mux output this cycle
- grant  output  N  one-hot registered grant; all-zero when idle
- sel  output  SEL_W  binary index of the granted requester; drives the mux select
- out_valid  output  1  mux output is valid this cycle (registered)
- ack  output  N  one-hot combinational transfer pulse: grant & req & {N{out_ready}}

Behaviour:
- Reset (async, immediate, overrides everything):
  - grant=0, sel=0, out_valid=0.
  - Priority pointer ptr=0, state=IDLE.
  - ack is therefore 0.
- States: IDLE, GRANT.
- Arbitration function:
  - Search req (masked as noted below) cyclically, starting at index ptr, upward.
  - The first set bit wins.
- IDLE:
  - If any req bit is set, the next edge registers grant=onehot(winner), sel=winner, out_valid=1, and enters GRANT.
  - Latency from req to grant is 1 cycle.
  - If no req bit is set, outputs stay 0.
- GRANT, transfer (req[sel]=1 and out_ready=1):
  - ack[sel]=1 in this cycle.
  - Next ptr = (sel+1) mod N, wrapping from N-1 to 0.
  - In the same cycle, re-arbitrate over req & ~grant, starting at the new ptr.
  - If that set is non-empty, the next edge loads the new winner with out_valid=1, giving back-to-back grants with no bubble.
  - If it is empty, the next edge goes to IDLE with grant=0 and out_valid=0.
  - The masking means the just-served requester cannot be re-granted on the cycle after its ack; it may win again from IDLE.
- GRANT, backpressure (req[sel]=1 and out_ready=0):
  - All state is held; grant and sel are stable and ack=0.
- GRANT, withdraw (req[sel]=0):
  - Takes precedence over out_ready; no ack is issued.
  - Next edge returns to IDLE with grant=0 and out_valid=0.
  - ptr is unchanged.
- Requests from non-granted requesters never disturb an active grant.
- Invariants:
  - grant is always one-hot or zero.
  - out_valid == |grant.
  - sel == index(grant) when out_valid=1; sel holds its last value when idle, and is 0 after reset.
- Requester obligation: req may drop on the cycle after ack. The arbiter does not depend on this, because of the masking above.

Decomposition:
- Shared include (package): IDLE/GRANT state encoding constants.
- Sub-module rr_priority_pick (purely combinational):
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: onehot[N], idx[SEL_W], any.
  - Implemented as double-width rotate-and-priority.
  - Instantiated once and fed by the IDLE/GRANT request mux (req vs req & ~grant, ptr vs next ptr).
- Top level holds only the state, ptr, grant and sel registers.

Test Plan (N=4):
1. Reset mid-grant: while grant=0100, out_valid=1, assert rst between edges -> grant=0000, out_valid=0, sel=0 immediately. After release with req=1000, grant=1000 after 1 edge.
2. Single requester: from reset, req=0100, out_ready=0 -> next edge grant=0100, sel=2, out_valid=1. Hold 3 cycles with ack=0. Then out_ready=1 -> ack=0100 that cycle; next edge grant=0000, out_valid=0; ptr=3.
3. Full load: req=1111 held, out_ready=1 continuously -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles; sel 0,1,2,3,0; out_valid continuously 1; one ack per cycle.
4. Backpressure: req=0011, out_ready=0 for 5 cycles -> grant=0001 and sel=0 stable, ack=0. Then out_ready=1 -> ack=0001; next edge grant=0010, sel=1.
5. Withdraw: from reset, req=0010 -> grant=0010. Drop req to 0000 with out_ready=1 -> ack=0000; next edge out_valid=0. Then req=0011 -> grant=0001 (ptr still 0).
6. Wrap and mask: grant=1000, req=1001, out_ready=1 -> ack=1000; next edge grant=0001, sel=0. Separately, with req=0001 only and ack=0001, the next edge returns to IDLE (grant=0000), and the following edge re-grants 0001.
